// File: rtl/vx_csr_bank.sv
// vx_csr_bank: per-warp CSR bank (fcsr, scratch, cycle/instret) behind a valid/ready request/response port.
// Define CSR_USER_CTR_EN to add NUM_USER_CTRS read-only user event counters at 0xB03+i / 0xB83+i.
module vx_csr_bank #(
    parameter int NUM_WARPS     = 4,
    parameter int XLEN          = 32,
    parameter int NUM_FPU_PORTS = 2,
    parameter int NUM_SCRATCH   = 4,
    parameter int CTR_WIDTH     = 48,
    parameter int COMMIT_WIDTH  = 4,
    parameter int NUM_USER_CTRS = 8,
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CW = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [XLEN-1:0]             startup_arg,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_op,
    input  logic [WW-1:0]               req_wid,
    input  logic [11:0]                 req_addr,
    input  logic [XLEN-1:0]             req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [XLEN-1:0]             rsp_data,
    output logic                        rsp_error,
    input  logic [NUM_FPU_PORTS-1:0]    fpu_valid,
    input  logic [NUM_FPU_PORTS*WW-1:0] fpu_wid,
    input  logic [NUM_FPU_PORTS*5-1:0]  fpu_fflags,
    input  logic [WW-1:0]               frm_wid,
    output logic [2:0]                  frm_out,
    input  logic [CW-1:0]               commit_cnt,
    input  logic [NUM_USER_CTRS-1:0]    user_events
);

    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_RW   = 2'd1;
    localparam logic [1:0] OP_RS   = 2'd2;
    localparam logic [1:0] OP_RC   = 2'd3;

`ifdef CSR_USER_CTR_EN
    localparam int NUM_CTRS = 2 + NUM_USER_CTRS;
`else
    localparam int NUM_CTRS = 2;
`endif
    localparam int CI   = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1;
    localparam int SI   = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
    localparam int HI_W = CTR_WIDTH - 32;

    // Counter index 0 = mcycle, 1 = minstret, 2+i = user counter i
    function automatic logic [11:0] ctr_addr(input int c);
        if (c == 0)
            return 12'hB00;
        else if (c == 1)
            return 12'hB02;
        else
            return 12'hB01 + 12'(c);
    endfunction

    logic                  rsp_valid_reg;
    logic [XLEN-1:0]       rsp_data_reg;
    logic                  rsp_error_reg;
    logic [XLEN-1:0]       scratch_reg [NUM_WARPS][NUM_SCRATCH];
    logic [HI_W-1:0]       snap_reg [NUM_WARPS][NUM_CTRS];
    logic                  snap_valid_reg [NUM_WARPS][NUM_CTRS];
    logic [CTR_WIDTH-1:0]  mcycle_reg;
    logic [CTR_WIDTH-1:0]  minstret_reg;

    logic [NUM_WARPS-1:0][7:0]          fcsr_all;
    logic [NUM_CTRS-1:0][CTR_WIDTH-1:0] ctr_val;

    logic            addr_legal, read_only;
    logic            sel_fflags, sel_frm, sel_fcsr, sel_scratch;
    logic [SI-1:0]   scratch_idx;
    logic            ctr_lo, ctr_hi;
    logic [CI-1:0]   ctr_idx;
    logic [HI_W-1:0] hi_bits;
    logic [7:0]      fcsr_cur;
    logic [XLEN-1:0] old_val, new_val;
    logic            wr_req, err, accept, do_write;

    assign req_ready = ~rsp_valid_reg | rsp_ready;
    assign accept    = req_valid & req_ready;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_error = rsp_error_reg;
    assign frm_out   = fcsr_all[frm_wid][7:5];
    assign fcsr_cur  = fcsr_all[req_wid];

    // Address decode and old-value mux
    always_comb begin
        addr_legal  = 1'b0;
        read_only   = 1'b0;
        sel_fflags  = 1'b0;
        sel_frm     = 1'b0;
        sel_fcsr    = 1'b0;
        sel_scratch = 1'b0;
        scratch_idx = '0;
        ctr_lo      = 1'b0;
        ctr_hi      = 1'b0;
        ctr_idx     = '0;
        hi_bits     = '0;
        old_val     = '0;
        case (req_addr)
            12'h001: begin addr_legal = 1'b1; sel_fflags = 1'b1; old_val = XLEN'(fcsr_cur[4:0]); end
            12'h002: begin addr_legal = 1'b1; sel_frm    = 1'b1; old_val = XLEN'(fcsr_cur[7:5]); end
            12'h003: begin addr_legal = 1'b1; sel_fcsr   = 1'b1; old_val = XLEN'(fcsr_cur); end
            12'hCC0: begin addr_legal = 1'b1; read_only  = 1'b1; old_val = XLEN'(req_wid); end
            default: ;
        endcase
        for (int k = 0; k < NUM_SCRATCH; k++) begin
            if (req_addr == 12'h340 + 12'(k)) begin
                addr_legal  = 1'b1;
                sel_scratch = 1'b1;
                scratch_idx = SI'(k);
                old_val     = scratch_reg[req_wid][k];
            end
        end
        for (int c = 0; c < NUM_CTRS; c++) begin
            if (req_addr == ctr_addr(c)) begin
                addr_legal = 1'b1;
                read_only  = 1'b1;
                ctr_lo     = 1'b1;
                ctr_idx    = CI'(c);
                old_val    = XLEN'(ctr_val[c]);
            end
            if ((XLEN == 32) && (req_addr == ctr_addr(c) + 12'h080)) begin
                addr_legal = 1'b1;
                read_only  = 1'b1;
                ctr_hi     = 1'b1;
                ctr_idx    = CI'(c);
                hi_bits    = snap_valid_reg[req_wid][c] ? snap_reg[req_wid][c]
                                                        : ctr_val[c][CTR_WIDTH-1:32];
                old_val    = XLEN'(hi_bits);
            end
        end
    end

    // RS/RC with a zero mask are pure reads and never count as writes
    assign wr_req   = (req_op == OP_RW) || ((req_op != OP_READ) && (req_data != '0));
    assign err      = ~addr_legal | (wr_req & read_only);
    assign do_write = accept & wr_req & ~err;

    always_comb begin
        case (req_op)
            OP_RW:   new_val = req_data;
            OP_RS:   new_val = old_val | req_data;
            OP_RC:   new_val = old_val & ~req_data;
            default: new_val = old_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_error_reg <= 1'b0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= err ? '0 : old_val;
            rsp_error_reg <= err;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++)
                for (int k = 0; k < NUM_SCRATCH; k++)
                    scratch_reg[w][k] <= (k == 0) ? startup_arg : '0;
        end else if (do_write && sel_scratch) begin
            scratch_reg[req_wid][scratch_idx] <= new_val;
        end
    end

    // Low-half read captures the upper bits so the following hi read cannot tear
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++)
                for (int c = 0; c < NUM_CTRS; c++) begin
                    snap_reg[w][c]       <= '0;
                    snap_valid_reg[w][c] <= 1'b0;
                end
        end else if (accept && !err && (XLEN == 32)) begin
            if (ctr_lo) begin
                snap_reg[req_wid][ctr_idx]       <= ctr_val[ctr_idx][CTR_WIDTH-1:32];
                snap_valid_reg[req_wid][ctr_idx] <= 1'b1;
            end
            if (ctr_hi)
                snap_valid_reg[req_wid][ctr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            mcycle_reg   <= mcycle_reg + CTR_WIDTH'(1);
            minstret_reg <= minstret_reg + CTR_WIDTH'(commit_cnt);
        end
    end

    assign ctr_val[0] = mcycle_reg;
    assign ctr_val[1] = minstret_reg;

`ifdef CSR_USER_CTR_EN
    generate
        for (genvar gi = 0; gi < NUM_USER_CTRS; gi++) begin : g_user_ctr
            logic [CTR_WIDTH-1:0] user_ctr_reg;
            always_ff @(posedge clk) begin
                if (reset)
                    user_ctr_reg <= '0;
                else if (user_events[gi])
                    user_ctr_reg <= user_ctr_reg + CTR_WIDTH'(1);
            end
            assign ctr_val[2+gi] = user_ctr_reg;
        end
    endgenerate
`else
    logic unused_user_events;
    assign unused_user_events = ^user_events;
`endif

    // Per-warp fcsr: CSR write result merged with every FPU flag update in the same cycle
    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [4:0] fpu_or;
            logic [7:0] fcsr_reg;
            logic [7:0] fcsr_next;

            always_comb begin
                fpu_or = '0;
                for (int p = 0; p < NUM_FPU_PORTS; p++)
                    if (fpu_valid[p] && (fpu_wid[p*WW +: WW] == WW'(gi)))
                        fpu_or = fpu_or | fpu_fflags[p*5 +: 5];
            end

            always_comb begin
                fcsr_next = fcsr_reg;
                if (do_write && (req_wid == WW'(gi))) begin
                    if (sel_fflags) fcsr_next[4:0] = new_val[4:0];
                    if (sel_frm)    fcsr_next[7:5] = new_val[2:0];
                    if (sel_fcsr)   fcsr_next      = new_val[7:0];
                end
                fcsr_next[4:0] = fcsr_next[4:0] | fpu_or;
            end

            always_ff @(posedge clk) begin
                if (reset)
                    fcsr_reg <= '0;
                else
                    fcsr_reg <= fcsr_next;
            end

            assign fcsr_all[gi] = fcsr_reg;
        end
    endgenerate

endmodule

// File: tb/tb_vx_csr_bank.sv
// Directed self-checking bench for vx_csr_bank: vector table plus hand sequences for
// fflags merging, counter snapshot, back-to-back and backpressure behaviour.
module tb_vx_csr_bank;

    localparam logic [1:0] RD = 2'd0, RW = 2'd1, RS = 2'd2, RC = 2'd3;
`ifdef CSR_USER_CTR_EN
    localparam logic USER_ERR = 1'b0;
`else
    localparam logic USER_ERR = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] startup_arg;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_wid;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [1:0]  fpu_valid;
    logic [3:0]  fpu_wid;
    logic [9:0]  fpu_fflags;
    logic [1:0]  frm_wid;
    logic [2:0]  frm_out;
    logic [2:0]  commit_cnt;
    logic [7:0]  user_events;

    int n_checks = 0;
    int n_fail   = 0;

    vx_csr_bank dut (
        .clk(clk), .reset(reset), .startup_arg(startup_arg),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_wid(req_wid), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .fpu_valid(fpu_valid), .fpu_wid(fpu_wid),
        .fpu_fflags(fpu_fflags), .frm_wid(frm_wid), .frm_out(frm_out),
        .commit_cnt(commit_cnt), .user_events(user_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  wid;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] wid, input logic [11:0] addr,
                                input logic [31:0] data, input logic [31:0] exp_data,
                                input logic exp_err, input string name);
        vec_t v;
        v.op = op; v.wid = wid; v.addr = addr; v.data = data;
        v.exp_data = exp_data; v.exp_err = exp_err; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] wid, input logic [11:0] addr,
                         input logic [31:0] data);
        req_valid = 1'b1; req_op = op; req_wid = wid; req_addr = addr; req_data = data;
    endtask

    // One request, response checked on the following falling edge
    task automatic do_txn(input logic [1:0] op, input logic [1:0] wid, input logic [11:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_d, input logic exp_e,
                          input string name);
        @(negedge clk);
        drive(op, wid, addr, data);
        @(negedge clk);
        req_valid = 1'b0;
        chk({name, ".valid"}, 64'(rsp_valid), 64'd1);
        chk({name, ".data"}, 64'(rsp_data), 64'(exp_d));
        chk({name, ".err"}, 64'(rsp_error), 64'(exp_e));
        $display("txn %s: op=%0d wid=%0d addr=0x%03h data=0x%08h -> rsp=0x%08h err=%0b",
                 name, op, wid, addr, data, rsp_data, rsp_error);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; startup_arg = 32'hCAFE_0000;
        req_valid = 1'b0; req_op = RD; req_wid = '0; req_addr = '0; req_data = '0;
        rsp_ready = 1'b1; fpu_valid = '0; fpu_wid = '0; fpu_fflags = '0;
        frm_wid = '0; commit_cnt = '0; user_events = '0;
        repeat (3) @(negedge clk);
        chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset.rsp_data", 64'(rsp_data), 64'd0);
        chk("reset.rsp_error", 64'(rsp_error), 64'd0);
        chk("reset.req_ready", 64'(req_ready), 64'd1);
        chk("reset.frm_out", 64'(frm_out), 64'd0);
        reset = 1'b0;

        vecs.push_back(mk(RD, 2, 12'h340, 32'h0,      32'hCAFE_0000, 0, "scr0_w2"));
        vecs.push_back(mk(RD, 2, 12'h341, 32'h0,      32'h0,         0, "scr1_w2"));
        vecs.push_back(mk(RW, 1, 12'h341, 32'hF0F0,   32'h0,         0, "rw_w1"));
        vecs.push_back(mk(RS, 1, 12'h341, 32'h000F,   32'hF0F0,      0, "rs_w1"));
        vecs.push_back(mk(RC, 1, 12'h341, 32'h00F0,   32'hF0FF,      0, "rc_w1"));
        vecs.push_back(mk(RD, 1, 12'h341, 32'h0,      32'hF00F,      0, "rd_w1"));
        vecs.push_back(mk(RD, 0, 12'h341, 32'h0,      32'h0,         0, "iso_w0"));
        vecs.push_back(mk(RD, 3, 12'hCC0, 32'h0,      32'h3,         0, "warpid"));
        vecs.push_back(mk(RS, 3, 12'hCC0, 32'h0,      32'h3,         0, "warpid_rs0"));
        vecs.push_back(mk(RW, 3, 12'hCC0, 32'h5,      32'h0,         1, "warpid_rw"));
        vecs.push_back(mk(RD, 0, 12'h7FF, 32'h0,      32'h0,         1, "illegal"));
        vecs.push_back(mk(RD, 0, 12'h344, 32'h0,      32'h0,         1, "scr_oob"));
        vecs.push_back(mk(RD, 0, 12'hB03, 32'h0,      32'h0,  USER_ERR, "user_ctr"));
        vecs.push_back(mk(RW, 0, 12'h343, 32'hDEAD_BEEF, 32'h0,      0, "rw_scr3"));
        vecs.push_back(mk(RD, 0, 12'h343, 32'h0,      32'hDEAD_BEEF, 0, "rd_scr3"));
        vecs.push_back(mk(RW, 2, 12'h002, 32'h5,      32'h0,         0, "frm_w2"));
        vecs.push_back(mk(RD, 2, 12'h003, 32'h0,      32'hA0,        0, "fcsr_w2"));
        vecs.push_back(mk(RC, 2, 12'h003, 32'hFF,     32'hA0,        0, "fcsr_rc"));
        vecs.push_back(mk(RS, 2, 12'h001, 32'h03,     32'h0,         0, "fflags_rs"));
        vecs.push_back(mk(RD, 2, 12'h003, 32'h0,      32'h03,        0, "fcsr_rd"));
        vecs.push_back(mk(RW, 0, 12'hB02, 32'h0,      32'h0,         1, "minstret_rw"));

        foreach (vecs[i])
            do_txn(vecs[i].op, vecs[i].wid, vecs[i].addr, vecs[i].data,
                   vecs[i].exp_data, vecs[i].exp_err, vecs[i].name);

        // Two FPU ports and a CSR fflags write all hit warp 0 in one cycle
        @(negedge clk);
        drive(RW, 0, 12'h001, 32'h10);
        fpu_valid = 2'b11; fpu_wid = {2'd0, 2'd0}; fpu_fflags = {5'h04, 5'h01};
        @(negedge clk);
        req_valid = 1'b0; fpu_valid = '0;
        chk("fmerge.old", 64'(rsp_data), 64'd0);
        $display("txn fmerge: RW fflags w0 0x10 with fpu 0x01|0x04 -> rsp=0x%08h", rsp_data);
        do_txn(RD, 0, 12'h001, 32'h0, 32'h15, 0, "fmerge_rd");

        // FPU update with no CSR access, warp 3 on port 1 then port 0
        @(negedge clk);
        fpu_valid = 2'b10; fpu_wid = {2'd3, 2'd0}; fpu_fflags = {5'h08, 5'h1F};
        @(negedge clk);
        fpu_valid = 2'b01; fpu_wid = {2'd0, 2'd3}; fpu_fflags = {5'h1F, 5'h02};
        @(negedge clk);
        fpu_valid = '0;
        do_txn(RD, 3, 12'h001, 32'h0, 32'h0A, 0, "fpu_w3");
        do_txn(RD, 0, 12'h001, 32'h0, 32'h15, 0, "fpu_w0_kept");

        // frm_out follows the registered frm, one cycle after the write
        @(negedge clk);
        frm_wid = 2'd1;
        drive(RW, 1, 12'h002, 32'h3);
        #1 chk("frm.before", 64'(frm_out), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("frm.after", 64'(frm_out), 64'd3);
        $display("txn frm: RW frm w1 3 -> frm_out=%0d", frm_out);

        // minstret accumulates commit_cnt
        @(negedge clk);
        commit_cnt = 3'd3;
        repeat (4) @(negedge clk);
        commit_cnt = 3'd0;
        do_txn(RD, 1, 12'hB02, 32'h0, 32'd12, 0, "minstret");
        do_txn(RD, 1, 12'hB82, 32'h0, 32'd0,  0, "minstreth");

        // Counter snapshot across the 32-bit carry
        @(negedge clk);
        force dut.mcycle_reg = 48'h0000_FFFF_FFFE;
        #1 release dut.mcycle_reg;
        drive(RD, 0, 12'hB00, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("snap.lo", 64'(rsp_data), 64'hFFFF_FFFE);
        $display("txn snap.lo: mcycle lo -> 0x%08h", rsp_data);
        @(negedge clk);
        drive(RD, 0, 12'hB80, 32'h0);
        @(negedge clk);
        chk("snap.hi", 64'(rsp_data), 64'd0);
        $display("txn snap.hi: mcycleh (snapshot) -> 0x%08h", rsp_data);
        drive(RD, 0, 12'hB80, 32'h0);
        @(negedge clk);
        chk("snap.live_hi", 64'(rsp_data), 64'd1);
        $display("txn snap.live_hi: mcycleh (live) -> 0x%08h", rsp_data);
        drive(RW, 0, 12'hB00, 32'h0);
        @(negedge clk);
        chk("ctr_rw.err", 64'(rsp_error), 64'd1);
        chk("ctr_rw.data", 64'(rsp_data), 64'd0);
        $display("txn ctr_rw: RW mcycle -> err=%0b", rsp_error);
        drive(RD, 0, 12'hB00, 32'h0);
        @(negedge clk);
        chk("ctr_after.lo", 64'(rsp_data), 64'd3);
        $display("txn ctr_after: mcycle lo -> 0x%08h", rsp_data);
        drive(RD, 0, 12'hB80, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ctr_after.hi", 64'(rsp_data), 64'd1);
        $display("txn ctr_after.hi: mcycleh -> 0x%08h", rsp_data);

        // Back-to-back requests, one per cycle
        @(negedge clk);
        drive(RD, 0, 12'h343, 32'h0);
        @(negedge clk);
        chk("b2b.first", 64'(rsp_data), 64'hDEAD_BEEF);
        $display("txn b2b.first -> 0x%08h", rsp_data);
        drive(RD, 2, 12'h340, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b.second_valid", 64'(rsp_valid), 64'd1);
        chk("b2b.second", 64'(rsp_data), 64'hCAFE_0000);
        $display("txn b2b.second -> 0x%08h", rsp_data);

        // Response backpressure for three cycles
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(RD, 1, 12'h341, 32'h0);
        @(negedge clk);
        drive(RW, 3, 12'h342, 32'h1111);
        for (int i = 0; i < 3; i++) begin
            chk("stall.req_ready", 64'(req_ready), 64'd0);
            chk("stall.rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall.rsp_data", 64'(rsp_data), 64'hF00F);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("release.valid", 64'(rsp_valid), 64'd1);
        chk("release.data", 64'(rsp_data), 64'd0);
        $display("txn stall: held rsp then RW scr2 w3 -> 0x%08h", rsp_data);
        @(negedge clk);
        chk("release.idle", 64'(rsp_valid), 64'd0);
        do_txn(RD, 3, 12'h342, 32'h0, 32'h1111, 0, "stall_rd");

        // Reset drops an in-flight request and reloads scratch[0]
        @(negedge clk);
        reset = 1'b1; startup_arg = 32'h1234_5678;
        drive(RD, 1, 12'h341, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_drop.valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_txn(RD, 3, 12'h340, 32'h0, 32'h1234_5678, 0, "rst_scr0");
        do_txn(RD, 1, 12'h341, 32'h0, 32'h0, 0, "rst_scr1");
        do_txn(RD, 0, 12'h003, 32'h0, 32'h0, 0, "rst_fcsr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_csr_bank.md
Name: vx_csr_bank

Overview:
- Per-warp CSR bank with a valid/ready request/response interface.
- Supports atomic read-modify-write ops (RW/RS/RC), per-warp FP control/status with multi-port flag accumulation, per-warp scratch registers, and free-running cycle/instret counters.
- On 32-bit XLEN, 64-bit counter reads are tear-free via a hi-half snapshot.
- Sits between the SFU CSR unit and the core's FPU/commit stages.

Parameters:
- NUM_WARPS, 4, warps served; wid width = max(1, clog2(NUM_WARPS)).
- XLEN, 32, data width; 32 or 64 only.
- NUM_FPU_PORTS, 2, independent FPU fflags write ports.
- NUM_SCRATCH, 4, scratch registers per warp (1..16).
- CTR_WIDTH, 48, cycle/instret counter width (33..64).
- COMMIT_WIDTH, 4, max instructions retired per cycle.
- NUM_USER_CTRS, 8, user event counters (optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- startup_arg  in  XLEN  reset value of scratch[0] for every warp
- req_valid  in  1  request valid
- req_ready  out  1  request accept
- req_op  in  2  0=read, 1=RW, 2=RS (set), 3=RC (clear)
- req_wid  in  clog2(NUM_WARPS)  requesting warp
- req_addr  in  12  CSR address
- req_data  in  XLEN  write/mask operand
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  XLEN  old CSR value
- rsp_error  out  1  illegal address or write to read-only
- fpu_valid  in  NUM_FPU_PORTS  fflags update strobes
- fpu_wid  in  NUM_FPU_PORTS*clog2(NUM_WARPS)  target warps
- fpu_fflags  in  NUM_FPU_PORTS*5  flags to OR in
- frm_wid  in  clog2(NUM_WARPS)  rounding-mode lookup warp
- frm_out  out  3  frm of frm_wid (combinational)
- commit_cnt  in  clog2(COMMIT_WIDTH+1)  instructions retired this cycle
- user_events  in  NUM_USER_CTRS  event increment strobes

Behaviour:
- Reset is synchronous, active-high, on clk.
  - rsp_valid=0, rsp_data=0, rsp_error=0.
  - All counters, fcsr (8 bits/warp: frm[7:5], fflags[4:0]) and snapshot-valid bits = 0.
  - scratch[w][0]=startup_arg, other scratch = 0.
  - A request in flight is dropped.
- Handshake and latency:
  - req_ready = ~rsp_valid | rsp_ready.
  - Accept on req_valid&req_ready; response registered, latency exactly 1 cycle.
  - rsp_* held stable while rsp_valid&~rsp_ready.
  - Back-to-back throughput is 1 request/cycle.
- Address map:
  - 0x001 FFLAGS, 0x002 FRM, 0x003 FCSR.
  - 0x340+k scratch k (k<NUM_SCRATCH).
  - 0xB00/0xB80 MCYCLE/H, 0xB02/0xB82 MINSTRET/H.
  - 0xCC0 WARP_ID (read-only, returns req_wid).
  - *H addresses are valid only when XLEN=32.
- RMW semantics: new = RW: data; RS: old|data; RC: old&~data.
  - RS/RC with req_data=0 is a pure read and never errors.
  - rsp_data = old value, zero-extended to XLEN.
  - State updates at the accept edge.
- Errors: illegal address, or any non-pure-read write to 0xCC0 or the counters.
  - Response is rsp_error=1, rsp_data=0, no state change.
- Counters:
  - mcycle += 1 every cycle.
  - minstret += commit_cnt.
  - Both wrap modulo 2^CTR_WIDTH; counters are not writable.
- Snapshot (XLEN=32 only):
  - An accepted low-half counter read latches bits [CTR_WIDTH-1:32] into snap[w][ctr] and sets snap_valid[w][ctr].
  - A subsequent hi read by the same warp returns the snapshot and clears the valid bit.
  - A hi read without a valid snapshot returns live bits.
  - The snapshot is per warp, so interleaved warps do not disturb each other.
- fflags accumulation:
  - Each cycle, for each port with fpu_valid set: fcsr[wid].fflags |= fpu_fflags.
  - Multiple ports hitting the same warp are all ORed.
  - When a CSR write to FFLAGS/FCSR and an FPU update hit the same warp in the same cycle: fflags = csr_new | fpu_flags, so no exception is lost.
  - The CSR response still returns the pre-update value.
- frm_out reflects the registered frm; a write becomes visible the next cycle.

Optional Feature:
- Macro: CSR_USER_CTR_EN.
- Defined:
  - NUM_USER_CTRS counters of CTR_WIDTH bits at 0xB03+i, with hi halves at 0xB83+i when XLEN=32.
  - Each increments by 1 when user_events[i] is set; reset to 0; read-only.
  - Hi halves take part in the snapshot scheme.
- Undefined:
  - user_events is ignored (tie-off lint waiver).
  - 0xB03.. addresses return rsp_error=1.

Test Plan:
- Reset with startup_arg=0xCAFE0000, then read 0x340 for warp 2 -> rsp_data=0xCAFE0000, error=0; read 0x341 -> 0.
- Warp1 RW 0x341 data=0xF0F0 -> returns 0; then RS 0x341 data=0x000F -> returns 0xF0F0; then RC 0x341 data=0x00F0 -> returns 0xF0FF; final read -> 0xF00F.
- Both FPU ports target warp 0 in the same cycle with fflags 0x01 and 0x04, while CSR writes FFLAGS=0x10 for warp 0 -> next read of 0x001 = 0x15.
- Preset mcycle to 0x0_FFFF_FFFE (via cycle count), read 0xB00 then 0xB80 two cycles later -> hi returns the snapshot, consistent with the low value (no tear across the 32-bit carry).
- Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_data stable, only one request accepted; release -> next request responds 1 cycle later.
- Write 0xB00 with RW -> rsp_error=1, counter unaffected; read 0x7FF -> rsp_error=1, rsp_data=0.
